// File: rtl/pc_flow_pkg.sv
// Shared encodings for the PC flow sequencer: PC branch select codes and FSM states.
package pc_flow_pkg;

    // Branch[2:0] codes understood by the PC mux
    typedef enum logic [2:0] {
        BR_SEQ = 3'b000,
        BR_BNE = 3'b001,
        BR_BEQ = 3'b010,
        BR_J   = 3'b011,
        BR_JR  = 3'b111
    } branch_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/pc_hazard_detect.sv
// Combinational hazard detection between the ID-stage source registers and the
// EX-stage destination. Register 0 never creates a dependency.
module pc_hazard_detect (
    input  logic       id_is_beq_i,
    input  logic       id_is_bne_i,
    input  logic       id_is_jr_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_rd_i,
    output logic       dep_o,
    output logic       load_use_o,
    output logic       br_haz_o
);

    logic id_needs_reg;

    assign dep_o = (ex_rd_i != 5'd0) &&
                   ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

    assign load_use_o = ex_mem_read_i && dep_o;

    // Branch compare and jr resolve in ID, so any in-flight EX write they read must wait
    assign id_needs_reg = id_is_beq_i || id_is_bne_i || id_is_jr_i;
    assign br_haz_o     = id_needs_reg && ex_reg_write_i && dep_o;

endmodule

// File: rtl/pc_flow_ctrl.sv
// PC/fetch sequencer: decodes ID control flow into Branch/PcSel, and drives
// PC hold, IF/ID flush and ID/EX bubble for load-use, ID-branch and mult/div hazards.
// Optional macro PC_FLOW_PERF_EN adds saturating stall/flush cycle counters.
module pc_flow_ctrl
    import pc_flow_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IdIsBeq,
    input  logic             IdIsBne,
    input  logic             IdIsJ,
    input  logic             IdIsJr,
    input  logic             IdCmpEq,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdUsesRt,
    input  logic             IdUsesMd,
    input  logic             ExMemRead,
    input  logic             ExRegWrite,
    input  logic [4:0]       ExRd,
    input  logic             MdBusy,
    output logic [2:0]       Branch,
    output logic             PcSel,
    output logic             Bobbles,
    output logic             IfIdFlush,
    output logic             IdExBubble,
    output logic             HazErr
`ifdef PC_FLOW_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt_o
`endif
);

    localparam int                WAIT_W     = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MD_MAX_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_e            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              haz_err_q, haz_err_d;

    branch_e br_c;
    logic    pcsel_c, bob_c, flush_c, bub_c;
    logic    taken, redirect;
    logic    dep_unused, load_use, br_haz;

    pc_hazard_detect u_haz (
        .id_is_beq_i   (IdIsBeq),
        .id_is_bne_i   (IdIsBne),
        .id_is_jr_i    (IdIsJr),
        .id_rs_i       (IdRs),
        .id_rt_i       (IdRt),
        .id_uses_rt_i  (IdUsesRt),
        .ex_mem_read_i (ExMemRead),
        .ex_reg_write_i(ExRegWrite),
        .ex_rd_i       (ExRd),
        .dep_o         (dep_unused),
        .load_use_o    (load_use),
        .br_haz_o      (br_haz)
    );

    assign taken = (IdIsBeq && IdCmpEq) || (IdIsBne && !IdCmpEq);

    // State, flush/wait counters and sticky watchdog error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= '0;
            haz_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            haz_err_q   <= haz_err_d;
        end
    end

    // Next-state and raw output decode; hazards outrank control-flow redirects
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        haz_err_d   = haz_err_q;
        br_c        = BR_SEQ;
        pcsel_c     = 1'b0;
        bob_c       = 1'b0;
        flush_c     = 1'b0;
        bub_c       = 1'b0;
        redirect    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (IdUsesMd && MdBusy) begin
                    bob_c      = 1'b1;
                    bub_c      = 1'b1;
                    state_d    = ST_MD_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else if (load_use || br_haz) begin
                    bob_c = 1'b1;
                    bub_c = 1'b1;
                end else begin
                    if (IdIsJr) begin
                        br_c = BR_JR;
                    end else if (IdIsJ) begin
                        br_c = BR_J;
                    end else if (IdIsBeq) begin
                        br_c    = BR_BEQ;
                        pcsel_c = taken;
                    end else if (IdIsBne) begin
                        br_c    = BR_BNE;
                        pcsel_c = taken;
                    end
                    redirect = IdIsJr || IdIsJ || taken;
                    if (redirect) begin
                        flush_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_LOAD;
                        end
                    end
                end
            end
            ST_MD_WAIT: begin
                bob_c = 1'b1;
                bub_c = 1'b1;
                if (!MdBusy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q >= WAIT_MAX) begin
                    haz_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ST_FLUSH: begin
                flush_c     = 1'b1;
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign Branch     = Reset ? BR_SEQ : br_c;
    assign PcSel      = Reset ? 1'b0 : pcsel_c;
    assign Bobbles    = Reset ? 1'b0 : bob_c;
    assign IfIdFlush  = Reset ? 1'b0 : flush_c;
    assign IdExBubble = Reset ? 1'b0 : bub_c;
    assign HazErr     = Reset ? 1'b0 : haz_err_q;

`ifdef PC_FLOW_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_perf_q;

    // Saturating counts of stall and flush cycles
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q  <= '0;
            flush_perf_q <= '0;
        end else begin
            if (Bobbles && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IfIdFlush && (flush_perf_q != '1)) begin
                flush_perf_q <= flush_perf_q + CNT_W'(1);
            end
        end
    end

    assign StallCnt   = stall_cnt_q;
    assign FlushCnt_o = flush_perf_q;
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Scoreboard bench for pc_flow_ctrl (FLUSH_CYCLES=3, MD_MAX_CYCLES=64).
// Define PC_FLOW_PERF_EN to also check the performance counters.
module tb_pc_flow_ctrl;

    localparam int FLUSH_CYCLES  = 3;
    localparam int MD_MAX_CYCLES = 64;
    localparam int CNT_W         = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       IdIsBeq, IdIsBne, IdIsJ, IdIsJr, IdCmpEq;
    logic [4:0] IdRs, IdRt;
    logic       IdUsesRt, IdUsesMd, ExMemRead, ExRegWrite;
    logic [4:0] ExRd;
    logic       MdBusy;
    logic [2:0] Branch;
    logic       PcSel, Bobbles, IfIdFlush, IdExBubble, HazErr;
`ifdef PC_FLOW_PERF_EN
    logic [CNT_W-1:0] StallCnt, FlushCnt_o;
    int exp_stall = 0;
    int exp_flush = 0;
`endif

    typedef struct packed {
        logic       rst;
        logic [2:0] br;
        logic       pcsel;
        logic       bob;
        logic       flush;
        logic       bub;
        logic       haz;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    pc_flow_ctrl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MD_MAX_CYCLES(MD_MAX_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .IdIsBeq   (IdIsBeq),
        .IdIsBne   (IdIsBne),
        .IdIsJ     (IdIsJ),
        .IdIsJr    (IdIsJr),
        .IdCmpEq   (IdCmpEq),
        .IdRs      (IdRs),
        .IdRt      (IdRt),
        .IdUsesRt  (IdUsesRt),
        .IdUsesMd  (IdUsesMd),
        .ExMemRead (ExMemRead),
        .ExRegWrite(ExRegWrite),
        .ExRd      (ExRd),
        .MdBusy    (MdBusy),
        .Branch    (Branch),
        .PcSel     (PcSel),
        .Bobbles   (Bobbles),
        .IfIdFlush (IfIdFlush),
        .IdExBubble(IdExBubble),
        .HazErr    (HazErr)
`ifdef PC_FLOW_PERF_EN
        ,
        .StallCnt  (StallCnt),
        .FlushCnt_o(FlushCnt_o)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        IdIsBeq = 0; IdIsBne = 0; IdIsJ = 0; IdIsJr = 0; IdCmpEq = 0;
        IdRs = 0; IdRt = 0; IdUsesRt = 0; IdUsesMd = 0;
        ExMemRead = 0; ExRegWrite = 0; ExRd = 0; MdBusy = 0;
    endtask

    // Push the expected outputs for the inputs now applied, then advance one cycle
    task automatic step(input string tag, input logic [2:0] br, input logic pc,
                        input logic bob, input logic fl, input logic bub, input logic hz);
        exp_t e;
        e.rst = Reset; e.br = br; e.pcsel = pc; e.bob = bob;
        e.flush = fl; e.bub = bub; e.haz = hz;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
    endtask

    // Pop and compare mid-cycle, away from the active edge
    always @(negedge Clk) begin : monitor
        exp_t  e;
        string t;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {24'd0, Branch, PcSel, Bobbles, IfIdFlush, IdExBubble, HazErr},
                   {24'd0, e.br, e.pcsel, e.bob, e.flush, e.bub, e.haz});
`ifdef PC_FLOW_PERF_EN
            chk({t, ".stallcnt"}, 32'(StallCnt), 32'(exp_stall));
            chk({t, ".flushcnt"}, 32'(FlushCnt_o), 32'(exp_flush));
            if (e.rst) begin
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                exp_stall += int'(e.bob);
                exp_flush += int'(e.flush);
            end
`endif
        end
    end

    initial begin
        clr_in();
        Reset = 1;
        @(posedge Clk);
        #1;
        step("rst0", 3'b000, 0, 0, 0, 0, 0);
        step("rst1", 3'b000, 0, 0, 0, 0, 0);
        Reset = 0;
        step("idle", 3'b000, 0, 0, 0, 0, 0);

        // beq taken: redirect + two further flush cycles, ID ignored meanwhile
        IdIsBeq = 1; IdCmpEq = 1;
        step("beq_taken", 3'b010, 1, 0, 1, 0, 0);
        clr_in(); IdIsJ = 1;
        step("beq_flush1", 3'b000, 0, 0, 1, 0, 0);
        step("beq_flush2", 3'b000, 0, 0, 1, 0, 0);
        clr_in();
        step("beq_done", 3'b000, 0, 0, 0, 0, 0);

        // reset held two cycles in the middle of a flush
        IdIsJ = 1;
        step("j", 3'b011, 0, 0, 1, 0, 0);
        clr_in(); Reset = 1;
        step("rst_mid_flush0", 3'b000, 0, 0, 0, 0, 0);
        step("rst_mid_flush1", 3'b000, 0, 0, 0, 0, 0);
        Reset = 0;
        step("post_rst_run", 3'b000, 0, 0, 0, 0, 0);

        // load-use on rs, then the bne proceeds
        ExMemRead = 1; ExRegWrite = 1; ExRd = 5; IdRs = 5; IdIsBne = 1; IdCmpEq = 1;
        step("loaduse", 3'b000, 0, 1, 0, 1, 0);
        ExMemRead = 0; ExRegWrite = 0;
        step("bne_after_lu", 3'b001, 0, 0, 0, 0, 0);

        // ID-branch hazard through rt; disappears when rt is not read
        clr_in(); ExRegWrite = 1; ExRd = 7; IdRt = 7; IdUsesRt = 1; IdIsBeq = 1; IdCmpEq = 1;
        step("brhaz_rt", 3'b000, 0, 1, 0, 1, 0);
        IdUsesRt = 0;
        step("rt_not_read", 3'b010, 1, 0, 1, 0, 0);
        clr_in();
        step("brhaz_flush1", 3'b000, 0, 0, 1, 0, 0);
        step("brhaz_flush2", 3'b000, 0, 0, 1, 0, 0);

        // EX write feeding a non-branch is not a hazard here
        ExRegWrite = 1; ExRd = 3; IdRs = 3;
        step("alu_dep_nostall", 3'b000, 0, 0, 0, 0, 0);

        // register 0 never stalls
        clr_in(); ExMemRead = 1; ExRd = 0; IdRs = 0; IdIsBne = 1; IdCmpEq = 1;
        step("r0_nostall", 3'b001, 0, 0, 0, 0, 0);

        // mult/div busy 4 cycles: 5 stall cycles then RUN
        clr_in(); IdUsesMd = 1; MdBusy = 1;
        for (int i = 0; i < 4; i++) step("md_busy", 3'b000, 0, 1, 0, 1, 0);
        MdBusy = 0;
        step("md_last_wait", 3'b000, 0, 1, 0, 1, 0);
        step("md_release", 3'b000, 0, 0, 0, 0, 0);

        // watchdog: HazErr appears after MD_MAX_CYCLES in MD_WAIT, sticky until reset
        MdBusy = 1;
        for (int i = 0; i < 70; i++) step("md_wd", 3'b000, 0, 1, 0, 1, (i >= 65));
        MdBusy = 0; IdUsesMd = 0;
        step("md_wd_exit", 3'b000, 0, 1, 0, 1, 1);
        step("hazerr_sticky", 3'b000, 0, 0, 0, 0, 1);
        Reset = 1;
        step("hazerr_rst", 3'b000, 0, 0, 0, 0, 0);
        Reset = 0;
        step("hazerr_cleared", 3'b000, 0, 0, 0, 0, 0);

        // jr outranks j
        IdIsJ = 1; IdIsJr = 1;
        step("jr_over_j", 3'b111, 0, 0, 1, 0, 0);
        clr_in();
        step("jr_flush1", 3'b000, 0, 0, 1, 0, 0);
        step("jr_flush2", 3'b000, 0, 0, 1, 0, 0);

        // mult/div stall outranks load-use and still waits one cycle in MD_WAIT
        IdUsesMd = 1; MdBusy = 1; ExMemRead = 1; ExRd = 5; IdRs = 5;
        step("md_over_lu", 3'b000, 0, 1, 0, 1, 0);
        MdBusy = 0; ExMemRead = 0;
        step("md_over_lu_wait", 3'b000, 0, 1, 0, 1, 0);
        clr_in();
        step("idle_end", 3'b000, 0, 0, 0, 0, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
